pc_ctx_sched: RTL
=================

// Module: pc_ctx_sched
// PURPOSE
//  Multi-context program counter with preemptive round-robin time slicing for the MIPS core.
//  Holds one saved PC per user context and counts retired user instructions.
//  When the quantum expires it saves the next PC and vectors to the kernel scheduler at KERNEL_PC.
//  On sched_ret it restores the next valid context. io_stall freezes the PC and the quantum count.
// PARAMETERS
//  AW          32      PC width (bits)
//  NUM_CTX     4       user contexts (>=2)
//  QUANTUM     10      user instructions retired per time slice
//  KERNEL_PC   32'h0   kernel/scheduler entry address
//  CTX_BASE    32'h400 reset PC of context 0
//  CTX_STRIDE  32'h400 reset PC spacing: ctx i starts at CTX_BASE+i*CTX_STRIDE
// PORTS
//  CLK        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high
//  pc_next    in   AW          next PC from fetch/branch logic (pc_out+4, target, ...)
//  pc_valid   in   1           one instruction retires this cycle; advance the PC
//  io_stall   in   1           input/output instruction waiting; hold PC and count
//  sched_ret  in   1           kernel finished; 1-cycle pulse; switch to the next context
//  ctx_valid  in   NUM_CTX     runnable-context mask (bit i = ctx i runnable)
//  ld_en      in   1           kernel write of a saved-PC slot
//  ld_ctx     in   clog2(N)    slot index for ld_en
//  ld_pc      in   AW          value for ld_en
//  pc_out     out  AW          current PC
//  cur_ctx    out  clog2(N)    active user context
//  user_mode  out  1           1 = user context running, 0 = kernel
//  ctx_switch out  1           1-cycle pulse on the cycle pc_out is reloaded from a slot
//  idle       out  1           kernel holding because ctx_valid==0 at sched_ret
// BEHAVIOUR
//  Reset values: pc_out=CTX_BASE; cur_ctx=0; user_mode=1; ctx_switch=0; idle=0; count=0.
//  Reset values (cont.): slot[i]=CTX_BASE+i*CTX_STRIDE.
//  FSM states are USER, KERNEL and STALL. All updates happen on posedge CLK.
//  USER, no stall, pc_valid, count<QUANTUM-1: pc_out<=pc_next; count++.
//  USER, no stall, pc_valid, count==QUANTUM-1: slot[cur_ctx]<=pc_next; pc_out<=KERNEL_PC;
//    user_mode<=0; count<=0; -> KERNEL. Exactly QUANTUM user instructions retire per slice.
//  USER, no stall, pc_valid=0: all state holds.
//  USER/KERNEL with io_stall=1 -> STALL; pc_out and count hold; pc_valid is ignored.
//  STALL -> return to the prior state on the first cycle io_stall=0.
//    The pending pc_valid in that cycle is applied normally.
//  Stall beats quantum expiry: an expiry-cycle stall defers the switch until the stall clears.
//  KERNEL, pc_valid: pc_out<=pc_next; count is not incremented (kernel is never preempted).
//  KERNEL, sched_ret: nxt = first i in (cur_ctx+1 .. cur_ctx+NUM_CTX) mod NUM_CTX with ctx_valid[i].
//    The search wraps and may return cur_ctx.
//    Action: pc_out<=slot[nxt]; cur_ctx<=nxt; user_mode<=1; ctx_switch<=1 for 1 cycle; -> USER.
//  sched_ret with ctx_valid==0: stay KERNEL; idle<=1 until the next sched_ret finds a valid ctx.
//  sched_ret with pc_valid in the same cycle: sched_ret wins; pc_next is discarded.
//  sched_ret while in USER is ignored.
//  ld_en writes slot[ld_ctx]<=ld_pc in any state.
//  ld_en collision with a quantum save to the same slot: the save wins.
//  ld_en collision with a restore read of the same slot: the restore reads the old value.
//  Latency: every PC update is visible on pc_out the cycle after the triggering edge.
//  Mid-operation reset returns all state, including slots, to reset values immediately (async).
//  Widths: count is clog2(QUANTUM+1) bits. Slot arithmetic is mod 2^AW.
//  ld_ctx>=NUM_CTX is ignored.
// CONFIGURATION
//  PC_SCHED_STATS_EN defined:
//    Adds output sw_count[31:0]: ctx_switch pulses since reset, wrapping at 2^32.
//    Adds output stall_cycles[31:0]: cycles spent in STALL, saturating at 2^32-1.
//  PC_SCHED_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  T1 Reset, ctx_valid=4'b1111, pc_valid=1, pc_next=pc_out+4 for 10 cycles.
//    -> pc_out 0x400..0x424, then 0x0; slot[0]=0x428; user_mode=0.
//  T2 From T1, sched_ret pulse -> pc_out=0x800, cur_ctx=1, ctx_switch=1 for 1 cycle.
//    Next expiry then sched_ret -> ctx 2 at 0xC00.
//  T3 ctx_valid=4'b1001, cur_ctx=0, sched_ret -> cur_ctx=3. Next slice + sched_ret -> wraps to ctx 0.
//    Ctx 0 resumes at its saved PC.
//  T4 io_stall=1 for 5 cycles at count=9 with pc_valid=1. -> pc_out and count frozen.
//    The switch to KERNEL_PC occurs on the first valid retire after the stall clears.
//  T5 ctx_valid=0 at sched_ret -> idle=1, user_mode=0.
//    Set ctx_valid=4'b0100, pulse sched_ret -> cur_ctx=2, idle=0.
//  T6 Assert reset mid-slice (count=5, cur_ctx=2) -> pc_out=0x400, cur_ctx=0, slots at reset values.
//    With PC_SCHED_STATS_EN: sw_count=0 after reset and increments by 1 per T2 switch.

Source files
------------

// File: rtl/pc_ctx_sched.sv
// Multi-context PC with preemptive round-robin time slicing into a kernel scheduler.
// Optional statistics counters (sw_count, stall_cycles) are enabled by defining PC_SCHED_STATS_EN.
module pc_ctx_sched #(
  parameter int            AW         = 32,
  parameter int            NUM_CTX    = 4,
  parameter int            QUANTUM    = 10,
  parameter logic [AW-1:0] KERNEL_PC  = 32'h0,
  parameter logic [AW-1:0] CTX_BASE   = 32'h400,
  parameter logic [AW-1:0] CTX_STRIDE = 32'h400,
  localparam int           CTXW       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [AW-1:0]      pc_next,
  input  logic               pc_valid,
  input  logic               io_stall,
  input  logic               sched_ret,
  input  logic [NUM_CTX-1:0] ctx_valid,
  input  logic               ld_en,
  input  logic [CTXW-1:0]    ld_ctx,
  input  logic [AW-1:0]      ld_pc,
`ifdef PC_SCHED_STATS_EN
  output logic [31:0]        sw_count,
  output logic [31:0]        stall_cycles,
`endif
  output logic [AW-1:0]      pc_out,
  output logic [CTXW-1:0]    cur_ctx,
  output logic               user_mode,
  output logic               ctx_switch,
  output logic               idle
);

  localparam int CW = $clog2(QUANTUM + 1);

  typedef enum logic [1:0] {USER, KERNEL, STALL} state_t;

  state_t          r_state;
  state_t          r_prior;
  state_t          w_eff;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_slot [NUM_CTX];
  logic [CTXW-1:0] w_nxt;
  logic            w_found;
  logic            w_restore;

  // Leaving STALL behaves exactly like the state it interrupted, so decode on that.
  always_comb begin
    w_eff = (r_state == STALL) ? r_prior : r_state;
  end

  always_comb begin
    logic [CTXW-1:0] idx;
    w_found = 1'b0;
    w_nxt   = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_CTX; i++) begin
      idx = CTXW'((32'(cur_ctx) + i) % NUM_CTX);
      if (!w_found && ctx_valid[idx]) begin
        w_found = 1'b1;
        w_nxt   = idx;
      end
    end
  end

  assign w_restore = !io_stall && (w_eff == KERNEL) && sched_ret && w_found;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= USER;
      r_prior    <= USER;
      r_count    <= '0;
      pc_out     <= CTX_BASE;
      cur_ctx    <= '0;
      user_mode  <= 1'b1;
      ctx_switch <= 1'b0;
      idle       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CTX; i++)
        r_slot[i] <= CTX_BASE + AW'(i) * CTX_STRIDE;
    end else begin
      ctx_switch <= 1'b0;
      if (ld_en && (32'(ld_ctx) < NUM_CTX))
        r_slot[ld_ctx] <= ld_pc;
      if (io_stall) begin
        r_state <= STALL;
        r_prior <= w_eff;
      end else if (w_eff == USER) begin
        r_state <= USER;
        if (pc_valid) begin
          if (r_count == CW'(QUANTUM - 1)) begin
            // Later assignment lets the quantum save override a same-slot kernel load.
            r_slot[cur_ctx] <= pc_next;
            pc_out          <= KERNEL_PC;
            user_mode       <= 1'b0;
            r_count         <= '0;
            r_state         <= KERNEL;
          end else begin
            pc_out  <= pc_next;
            r_count <= r_count + 1'b1;
          end
        end
      end else begin
        r_state <= KERNEL;
        if (w_restore) begin
          pc_out     <= r_slot[w_nxt];
          cur_ctx    <= w_nxt;
          user_mode  <= 1'b1;
          ctx_switch <= 1'b1;
          idle       <= 1'b0;
          r_state    <= USER;
        end else if (sched_ret) begin
          idle <= 1'b1;
        end else if (pc_valid) begin
          pc_out <= pc_next;
        end
      end
    end
  end

`ifdef PC_SCHED_STATS_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sw_count     <= '0;
      stall_cycles <= '0;
    end else begin
      if (w_restore)
        sw_count <= sw_count + 32'd1;
      if ((r_state == STALL) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
